// File: rtl/cache_array_access_ctrl.sv
// Lookup/fill controller in front of the dual-port tag/data SRAM array.
// Two-stage pipe (issue read, compare) feeding a registered response with victim info.
module cache_array_access_ctrl #(
  parameter int unsigned ADDR_W = 31,
  parameter int unsigned IDX_W  = 9,
  parameter int unsigned OFF_W  = 6
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              req_valid,
  output logic                              req_ready,
  input  logic [ADDR_W-1:0]                 req_addr,
  input  logic                              req_we,
  input  logic [31:0]                       req_wdata,
  input  logic [3:0]                        req_wstrb,
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic                              rsp_hit,
  output logic [31:0]                       rsp_rdata,
  output logic                              rsp_victim_valid,
  output logic                              rsp_victim_dirty,
  output logic [ADDR_W-IDX_W-OFF_W-1:0]     rsp_victim_tag,
  output logic [(8<<OFF_W)-1:0]             rsp_victim_data,
  input  logic                              fill_valid,
  output logic                              fill_ready,
  input  logic [ADDR_W-1:0]                 fill_addr,
  input  logic [(8<<OFF_W)-1:0]             fill_data,
  output logic                              sram_rden_o,
  output logic [IDX_W-1:0]                  sram_raddr_o,
  input  logic [ADDR_W-IDX_W-OFF_W+1:0]     sram_rdata_tag_i,
  input  logic [(8<<OFF_W)-1:0]             sram_rdata_data_i,
  output logic                              sram_wren_o,
  output logic [IDX_W-1:0]                  sram_waddr_o,
  output logic [ADDR_W-IDX_W-OFF_W+1:0]     sram_wdata_tag_o,
  output logic [(8<<OFF_W)-1:0]             sram_wdata_data_o
);

  localparam int unsigned TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int unsigned ENT_W  = TAG_W + 2;
  localparam int unsigned LINE_W = 8 << OFF_W;
  localparam int unsigned WIDX_W = OFF_W - 2;
  localparam int unsigned BIT_W  = OFF_W + 3;

  logic [IDX_W-1:0]  req_idx, fill_idx, s1_idx;
  logic [TAG_W-1:0]  req_tag, fill_tag, s1_tag;
  logic [WIDX_W-1:0] req_word, s1_word;
  logic              a_xfer, s1_adv, wr_hit, fill_xfer;
  logic              s1_valid, s1_fresh, s1_we, s1_hit;
  logic [31:0]       s1_wdata, sel_word, merged_word;
  logic [3:0]        s1_wstrb;
  logic [ENT_W-1:0]  s1_ent, eff_ent;
  logic [LINE_W-1:0] s1_line, eff_line, merged_line;
  logic [BIT_W-1:0]  word_base;
  logic              unused_addr_bits;

  assign req_idx  = req_addr[OFF_W +: IDX_W];
  assign req_tag  = req_addr[OFF_W+IDX_W +: TAG_W];
  assign req_word = req_addr[2 +: WIDX_W];
  assign fill_idx = fill_addr[OFF_W +: IDX_W];
  assign fill_tag = fill_addr[OFF_W+IDX_W +: TAG_W];
  assign unused_addr_bits = ^{req_addr[1:0], fill_addr[OFF_W-1:0]};

  // Handshakes and read issue
  assign s1_adv      = s1_valid & (~rsp_valid | rsp_ready);
  assign req_ready   = rst_n & (~s1_valid | s1_adv);
  assign a_xfer      = req_valid & req_ready;
  assign sram_rden_o = a_xfer;
  assign sram_raddr_o = req_idx;

  // SRAM output is only valid in S1's first cycle, and only if no same-cycle write raced the read
  assign eff_ent  = s1_fresh ? sram_rdata_tag_i  : s1_ent;
  assign eff_line = s1_fresh ? sram_rdata_data_i : s1_line;
  assign s1_hit   = eff_ent[ENT_W-1] & (eff_ent[TAG_W-1:0] == s1_tag);

  assign word_base   = {s1_word, 5'd0};
  assign sel_word    = eff_line[word_base +: 32];
  assign merged_word = merged_line[word_base +: 32];

  always_comb begin
    merged_line = eff_line;
    for (int b = 0; b < 4; b++) begin
      if (s1_wstrb[b]) merged_line[word_base + BIT_W'(8*b) +: 8] = s1_wdata[8*b +: 8];
    end
  end

  // Single write port: a write hit leaving S1 wins over a refill
  assign wr_hit            = rst_n & s1_adv & s1_hit & s1_we;
  assign fill_ready        = rst_n & ~(s1_adv & s1_hit & s1_we);
  assign fill_xfer         = fill_valid & fill_ready;
  assign sram_wren_o       = wr_hit | fill_xfer;
  assign sram_waddr_o      = wr_hit ? s1_idx : fill_idx;
  assign sram_wdata_tag_o  = wr_hit ? {2'b11, s1_tag} : {2'b10, fill_tag};
  assign sram_wdata_data_o = wr_hit ? merged_line : fill_data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_fresh <= 1'b0;
    end else if (a_xfer) begin
      s1_valid <= 1'b1;
      s1_fresh <= ~(sram_wren_o & (sram_waddr_o == req_idx));
    end else begin
      if (s1_adv) s1_valid <= 1'b0;
      s1_fresh <= 1'b0;
    end
  end

  // S1 payload and local entry copy; the write entry is taken on accept so a racing write is bypassed
  always_ff @(posedge clk) begin
    if (a_xfer) begin
      s1_we    <= req_we;
      s1_tag   <= req_tag;
      s1_idx   <= req_idx;
      s1_word  <= req_word;
      s1_wdata <= req_wdata;
      s1_wstrb <= req_wstrb;
      s1_ent   <= sram_wdata_tag_o;
      s1_line  <= sram_wdata_data_o;
    end else if (sram_wren_o && (sram_waddr_o == s1_idx)) begin
      s1_ent   <= sram_wdata_tag_o;
      s1_line  <= sram_wdata_data_o;
    end else begin
      s1_ent   <= eff_ent;
      s1_line  <= eff_line;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid        <= 1'b0;
      rsp_hit          <= 1'b0;
      rsp_rdata        <= '0;
      rsp_victim_valid <= 1'b0;
      rsp_victim_dirty <= 1'b0;
      rsp_victim_tag   <= '0;
      rsp_victim_data  <= '0;
    end else if (s1_adv) begin
      rsp_valid        <= 1'b1;
      rsp_hit          <= s1_hit;
      rsp_rdata        <= s1_hit ? (s1_we ? merged_word : sel_word) : 32'd0;
      rsp_victim_valid <= ~s1_hit & eff_ent[ENT_W-1];
      rsp_victim_dirty <= ~s1_hit & eff_ent[ENT_W-2];
      rsp_victim_tag   <= s1_hit ? '0 : eff_ent[TAG_W-1:0];
      rsp_victim_data  <= s1_hit ? '0 : eff_line;
    end else if (rsp_ready) begin
      rsp_valid        <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cache_array_access_ctrl.sv
// Bench for cache_array_access_ctrl: behavioural SRAM, directed scenarios, then random traffic
// checked against a set-array cache model updated in request-acceptance order.
module tb_cache_array_access_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid, req_ready, req_we;
  logic [30:0]  req_addr;
  logic [31:0]  req_wdata;
  logic [3:0]   req_wstrb;
  logic         rsp_valid, rsp_ready, rsp_hit;
  logic [31:0]  rsp_rdata;
  logic         rsp_victim_valid, rsp_victim_dirty;
  logic [15:0]  rsp_victim_tag;
  logic [511:0] rsp_victim_data;
  logic         fill_valid, fill_ready;
  logic [30:0]  fill_addr;
  logic [511:0] fill_data;
  logic         sram_rden_o, sram_wren_o;
  logic [8:0]   sram_raddr_o, sram_waddr_o;
  logic [17:0]  sram_wdata_tag_o;
  logic [511:0] sram_wdata_data_o;
  bit   [17:0]  rd_tag;
  bit   [511:0] rd_data;

  cache_array_access_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_we(req_we),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit), .rsp_rdata(rsp_rdata),
    .rsp_victim_valid(rsp_victim_valid), .rsp_victim_dirty(rsp_victim_dirty),
    .rsp_victim_tag(rsp_victim_tag), .rsp_victim_data(rsp_victim_data),
    .fill_valid(fill_valid), .fill_ready(fill_ready), .fill_addr(fill_addr), .fill_data(fill_data),
    .sram_rden_o(sram_rden_o), .sram_raddr_o(sram_raddr_o),
    .sram_rdata_tag_i(rd_tag), .sram_rdata_data_i(rd_data),
    .sram_wren_o(sram_wren_o), .sram_waddr_o(sram_waddr_o),
    .sram_wdata_tag_o(sram_wdata_tag_o), .sram_wdata_data_o(sram_wdata_data_o)
  );

  always #5 clk = ~clk;

  // Dual-port SRAM, one-cycle read latency, read-during-write returns old contents
  bit [17:0]  mem_tag  [512];
  bit [511:0] mem_data [512];
  always @(posedge clk) begin
    if (sram_rden_o) begin
      rd_tag  <= mem_tag[sram_raddr_o];
      rd_data <= mem_data[sram_raddr_o];
    end
    if (sram_wren_o) begin
      mem_tag[sram_waddr_o]  <= sram_wdata_tag_o;
      mem_data[sram_waddr_o] <= sram_wdata_data_o;
    end
  end

  // Reference cache state
  bit         m_valid [512];
  bit         m_dirty [512];
  bit [15:0]  m_tag   [512];
  bit [511:0] m_data  [512];

  typedef struct packed {
    logic         hit;
    logic [31:0]  rdata;
    logic         vv;
    logic         vd;
    logic [15:0]  vt;
    logic [511:0] vdata;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int n_req = 0;
  int n_rsp = 0;
  logic         r_hit, r_vv, r_vd;
  logic [31:0]  r_rdata;
  logic [15:0]  r_vt;
  logic [511:0] r_vdata;
  int           idx_tbl [4];

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_fill(input logic [30:0] a, input logic [511:0] d);
    int i = int'(a[14:6]);
    m_valid[i] = 1'b1;
    m_dirty[i] = 1'b0;
    m_tag[i]   = a[30:15];
    m_data[i]  = d;
  endfunction

  function automatic exp_t model_access(input logic [30:0] a, input logic we,
                                        input logic [31:0] wd, input logic [3:0] st);
    exp_t e;
    int i = int'(a[14:6]);
    int w = int'(a[5:2]);
    e = '0;
    e.hit = m_valid[i] && (m_tag[i] == a[30:15]);
    if (e.hit) begin
      if (we) begin
        for (int b = 0; b < 4; b++)
          if (st[b]) m_data[i][w*32 + b*8 +: 8] = wd[b*8 +: 8];
        m_dirty[i] = 1'b1;
      end
      e.rdata = m_data[i][w*32 +: 32];
    end else begin
      e.vv = m_valid[i];
      e.vd = m_dirty[i];
      e.vt = m_tag[i];
      e.vdata = m_data[i];
    end
    return e;
  endfunction

  function automatic logic [511:0] mk_line(input logic [31:0] seed);
    logic [511:0] l;
    for (int w = 0; w < 16; w++) l[w*32 +: 32] = seed + 32'(w);
    return l;
  endfunction

  task automatic issue(input logic [30:0] a, input logic we, input logic [31:0] wd, input logic [3:0] st);
    int n = 0;
    req_valid = 1'b1; req_addr = a; req_we = we; req_wdata = wd; req_wstrb = st;
    #1;
    while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (n == 50) check("issue_timeout", req_ready, 1'b1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // Capture the next response (bounded) and let it transfer
  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    if (lat == 20) check("rsp_timeout", rsp_valid, 1'b1);
    r_hit = rsp_hit; r_rdata = rsp_rdata; r_vv = rsp_victim_valid;
    r_vd = rsp_victim_dirty; r_vt = rsp_victim_tag; r_vdata = rsp_victim_data;
    @(posedge clk); #1;
  endtask

  task automatic do_fill(input logic [30:0] a, input logic [511:0] d);
    int n = 0;
    fill_valid = 1'b1; fill_addr = a; fill_data = d;
    #1;
    while (!fill_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (n == 50) check("fill_timeout", fill_ready, 1'b1);
    check("fill_wren", sram_wren_o, 1'b1);
    @(posedge clk); #1;
    fill_valid = 1'b0;
    model_fill(a, d);
  endtask

  function automatic logic [30:0] rand_addr();
    logic [15:0] t = 16'($urandom_range(0, 2));
    logic [8:0]  i = 9'(idx_tbl[$urandom_range(0, 3)]);
    logic [3:0]  w = 4'($urandom_range(0, 15));
    return {t, i, w, 2'b00};
  endfunction

  task automatic rand_cycle(input bit allow_new);
    bit acc = 1'b0;
    exp_t e;
    if (allow_new && !req_valid && $urandom_range(0, 3) != 0) begin
      req_valid = 1'b1;
      req_addr  = rand_addr();
      req_we    = ($urandom_range(0, 3) == 0);
      req_wdata = $urandom;
      req_wstrb = 4'($urandom_range(0, 15));
    end
    rsp_ready = allow_new ? 1'($urandom_range(0, 1)) : 1'b1;
    #1;
    if (req_valid && req_ready) begin
      q.push_back(model_access(req_addr, req_we, req_wdata, req_wstrb));
      n_req++;
      acc = 1'b1;
    end
    if (rsp_valid && rsp_ready) begin
      n_rsp++;
      if (q.size() == 0) check("rnd_unexpected_rsp", rsp_valid, 1'b0);
      else begin
        e = q.pop_front();
        check("rnd_hit", rsp_hit, e.hit);
        check("rnd_rdata", rsp_rdata, e.rdata);
        check("rnd_victim_valid", rsp_victim_valid, e.vv);
        check("rnd_victim_dirty", rsp_victim_dirty, e.vd);
        check("rnd_victim_tag", rsp_victim_tag, e.vt);
        check("rnd_victim_data", rsp_victim_data, e.vdata);
      end
    end
    @(posedge clk); #1;
    if (acc) req_valid = 1'b0;
  endtask

  initial begin
    int lat;
    logic [511:0] line;
    idx_tbl = '{32'h041, 32'h042, 32'h000, 32'h003};
    rst_n = 1'b0; rsp_ready = 1'b1;
    req_valid = 1'b1; req_addr = 31'h0000_1040; req_we = 1'b0; req_wdata = '0; req_wstrb = '0;
    fill_valid = 1'b1; fill_addr = 31'h0000_1040; fill_data = '0;

    // 1: reset state, first miss and its latency
    repeat (3) @(posedge clk);
    #1;
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rden", sram_rden_o, 1'b0);
    check("rst_wren", sram_wren_o, 1'b0);
    check("rst_fill_ready", fill_ready, 1'b0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    req_valid = 1'b0; fill_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    issue(31'h0000_1040, 1'b0, 32'd0, 4'd0);
    wait_rsp(lat);
    // second cycle after the accept cycle = first edge after the accepting edge
    check("t1_latency", lat, 1);
    check("t1_hit", r_hit, 1'b0);
    check("t1_victim_valid", r_vv, 1'b0);
    check("t1_rdata", r_rdata, 32'd0);

    // 2: refill then hit
    line = mk_line(32'h0000_1000);
    line[63:32] = 32'hDEAD_BEEF;
    do_fill(31'h0000_1040, line);
    issue(31'h0000_1044, 1'b0, 32'd0, 4'd0);
    wait_rsp(lat);
    check("t2_hit", r_hit, 1'b1);
    check("t2_rdata", r_rdata, 32'hDEAD_BEEF);

    // 3: write hit then back-to-back read through the bypass, then dirty victim
    issue(31'h0000_1044, 1'b1, 32'h1122_3344, 4'h3);
    void'(model_access(31'h0000_1044, 1'b1, 32'h1122_3344, 4'h3));
    issue(31'h0000_1044, 1'b0, 32'd0, 4'd0);
    wait_rsp(lat);
    check("t3_wr_hit", r_hit, 1'b1);
    check("t3_wr_rdata", r_rdata, 32'hDEAD_3344);
    wait_rsp(lat);
    check("t3_rd_hit", r_hit, 1'b1);
    check("t3_rd_rdata", r_rdata, 32'hDEAD_3344);
    issue(31'h0000_9040, 1'b0, 32'd0, 4'd0);
    wait_rsp(lat);
    check("t3_miss_hit", r_hit, 1'b0);
    check("t3_victim_valid", r_vv, 1'b1);
    check("t3_victim_dirty", r_vd, 1'b1);
    check("t3_victim_tag", r_vt, 16'h0000);
    check("t3_victim_word1", r_vdata[63:32], 32'hDEAD_3344);

    // 4: S1 stalled on idx 0x41 while a refill for its tag lands
    rsp_ready = 1'b0;
    issue(31'h0000_0000, 1'b0, 32'd0, 4'd0);
    issue(31'h0000_9044, 1'b0, 32'd0, 4'd0);
    check("t4_req_ready_stalled", req_ready, 1'b0);
    line = mk_line(32'h0900_0000);
    line[63:32] = 32'hCAFE_F00D;
    do_fill(31'h0000_9040, line);
    @(posedge clk); #1;
    check("t4_rsp_held", rsp_valid, 1'b1);
    rsp_ready = 1'b1;
    wait_rsp(lat);
    check("t4_first_hit", r_hit, 1'b0);
    wait_rsp(lat);
    check("t4_snoop_hit", r_hit, 1'b1);
    check("t4_snoop_rdata", r_rdata, 32'hCAFE_F00D);

    // 5: write hit leaving S1 collides with a refill of the same set
    rsp_ready = 1'b0;
    issue(31'h0000_9044, 1'b1, 32'hA5A5_A5A5, 4'hF);
    line = mk_line(32'h1100_0000);
    line[63:32] = 32'h5EED_0001;
    fill_valid = 1'b1; fill_addr = 31'h0001_1040; fill_data = line;
    #1;
    check("t5_fill_blocked", fill_ready, 1'b0);
    check("t5_wren_wr", sram_wren_o, 1'b1);
    check("t5_wtag_wr", sram_wdata_tag_o, {2'b11, 16'h0001});
    check("t5_waddr_wr", sram_waddr_o, 9'h041);
    @(posedge clk); #1;
    check("t5_fill_ready_next", fill_ready, 1'b1);
    check("t5_wtag_fill", sram_wdata_tag_o, {2'b10, 16'h0002});
    @(posedge clk); #1;
    fill_valid = 1'b0;
    void'(model_access(31'h0000_9044, 1'b1, 32'hA5A5_A5A5, 4'hF));
    model_fill(31'h0001_1040, line);
    rsp_ready = 1'b1;
    wait_rsp(lat);
    check("t5_wr_hit", r_hit, 1'b1);
    check("t5_wr_rdata", r_rdata, 32'hA5A5_A5A5);
    issue(31'h0001_1044, 1'b0, 32'd0, 4'd0);
    wait_rsp(lat);
    check("t5_fill_hit", r_hit, 1'b1);
    check("t5_fill_rdata", r_rdata, 32'h5EED_0001);

    // 6: randomized reads/writes with random backpressure against the model
    for (int k = 0; k < 4; k++)
      do_fill({16'($urandom_range(0, 2)), 9'(idx_tbl[k]), 6'd0},
              {16{32'($urandom)}} ^ mk_line($urandom));
    for (int c = 0; c < 600; c++) rand_cycle(1'b1);
    for (int c = 0; c < 20; c++) rand_cycle(1'b0);
    check("rnd_queue_drained", 32'(q.size()), 32'd0);
    check("rnd_rsp_count", n_rsp, n_req);

    // Reset with a request in flight produces no response
    issue(31'h0000_1040, 1'b0, 32'd0, 4'd0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    lat = 0;
    for (int c = 0; c < 4; c++) begin
      if (rsp_valid) lat++;
      @(posedge clk); #1;
    end
    check("reset_drops_inflight", lat, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
